// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, reads a 1-cycle synchronous imem, buffers {instr, pc} for decode.
// Latency: request at cycle N, data back at N+1, out_valid at N+2; a redirect costs 3 cycles to the first target instruction.
// Backpressure: out_ready low fills the buffer, then im_req stops; a redirect flushes the buffer and any in-flight read.
module fetch_unit #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instru,
    output logic [31:0] out_pc
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   instr_buf [FIFO_DEPTH];
    logic [31:0]   pc_buf    [FIFO_DEPTH];
    logic [31:0]   head_instru;
    logic [31:0]   head_pc;

    logic          head_vld;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy;
    logic [CW-1:0] count_after_pop;
    logic [PW-1:0] rd_next;

    // Handshake and issue decisions; redirect and reset suppress everything.
    always_comb begin
        head_vld        = (count != '0);
        pop             = rst_n & head_vld & out_ready & ~redirect_valid;
        push            = rst_n & inflight & ~redirect_valid;
        // Slots already claimed (buffered plus in flight) once this cycle's pop leaves.
        occupancy       = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
        issue           = rst_n & ~redirect_valid & (occupancy < (CW+1)'(FIFO_DEPTH));
        count_after_pop = count - CW'(pop);
        rd_next         = rd_ptr + PW'(pop);
    end

    assign im_req     = issue;
    assign im_addr    = fetch_pc;
    assign out_valid  = rst_n & head_vld;
    assign out_instru = rst_n ? head_instru : 32'h0;
    assign out_pc     = rst_n ? head_pc : 32'h0;

    // Buffer storage: written only on a return push, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_buf[wr_ptr] <= im_rdata;
            pc_buf[wr_ptr]    <= inflight_pc;
        end
    end

    // PC, in-flight tracking, buffer pointers and the registered head copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= PC_RESET;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            head_instru <= 32'h0;
            head_pc     <= 32'h0;
        end else if (redirect_valid) begin
            // Drop buffered and in-flight work; head registers keep their last values.
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
            end else begin
                inflight <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count + CW'(push) - CW'(pop);
            // Next head comes from storage if entries remain after the pop, else from the
            // arriving word; with nothing left the head registers hold their last values.
            if (count_after_pop != '0) begin
                head_instru <= instr_buf[rd_next];
                head_pc     <= pc_buf[rd_next];
            end else if (push) begin
                head_instru <= im_rdata;
                head_pc     <= inflight_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem returning address-encoded words, scoreboard of expected {pc, instr}.
// Each reset release or redirect loads the expected sequential stream; every accepted output is popped and compared.
// Directed checks cover reset outputs, first-fetch timing, throughput, stall behaviour, redirect latency and PC wrap.
module tb_fetch_unit;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instru;
    logic [31:0] out_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;
    int   n_vld;

    always #5 clk = ~clk;

    fetch_unit #(.PC_RESET(PC_RESET), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .im_req        (im_req),
        .im_addr       (im_addr),
        .im_rdata      (im_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instru    (out_instru),
        .out_pc        (out_pc)
    );

    function automatic logic [31:0] enc(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (im_req) im_rdata <= enc(im_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic expect_stream(input logic [31:0] start);
        logic [31:0] p;
        sb.delete();
        for (int i = 0; i < 48; i++) begin
            p = start + 32'(i * 4);
            sb.push_back('{pc: p, ins: enc(p)});
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Every accepted output must match the head of the expected stream.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            pops++;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("out_pc", out_pc, mon_e.pc);
                check("out_instru", out_instru, mon_e.ins);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        repeat (3) next_cycle();

        // Reset outputs
        @(negedge clk);
        check("rst_im_req", 32'(im_req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instru", out_instru, 32'h0);

        // 1: first fetches after reset release
        next_cycle();
        rst_n = 1'b1;
        expect_stream(PC_RESET);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t1_im_req", 32'(im_req), 32'd1);
            check("t1_im_addr", im_addr, PC_RESET + 32'(c * 4));
            check("t1_out_valid", 32'(out_valid), 32'(c == 2));
            next_cycle();
        end

        // 2: one instruction per cycle with out_ready high
        n_vld = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) n_vld++;
            next_cycle();
        end
        check("t2_throughput", 32'(n_vld), 32'd20);

        // 3: stall for 5 cycles, head must stay the next expected entry
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_valid", 32'(out_valid), 32'd1);
            check("t3_head_pc", out_pc, sb[0].pc);
            if (k == 4) check("t3_im_req", 32'(im_req), 32'd0);
            next_cycle();
        end
        out_ready = 1'b1;
        repeat (4) next_cycle();

        // 4: redirect mid-stream with a read in flight
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        expect_stream(32'h0000_0100);
        @(negedge clk);
        check("t4_redir_req", 32'(im_req), 32'd0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_valid_r1", 32'(out_valid), 32'd0);
        check("t4_addr_r1", im_addr, 32'h0000_0100);
        check("t4_req_r1", 32'(im_req), 32'd1);
        next_cycle();
        @(negedge clk);
        check("t4_valid_r2", 32'(out_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check("t4_valid_r3", 32'(out_valid), 32'd1);
        check("t4_pc_r3", out_pc, 32'h0000_0100);
        repeat (6) next_cycle();

        // 5: redirect from a full buffer to a target that wraps through zero
        out_ready = 1'b0;
        repeat (3) next_cycle();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        expect_stream(32'hFFFF_FFF8);
        next_cycle();
        redirect_valid = 1'b0;
        repeat (8) next_cycle();
        check("t5_wrap_consumed", 32'(sb.size() <= 45), 32'd1);

        // 6: single-cycle reset with a full buffer
        out_ready = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b0;
        expect_stream(PC_RESET);
        @(negedge clk);
        check("t6_rst_req", 32'(im_req), 32'd0);
        next_cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_addr", im_addr, PC_RESET);
        repeat (8) next_cycle();

        check("total_pops", 32'(pops >= 30), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
